ysyx_24080014_lsu: RTL

//  Load/store unit: the initiator side of the data-memory port. Takes one load/store from EXU,

---
 rtl/ysyx_24080014_lsu.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/ysyx_24080014_lsu.sv
// Load/store unit: takes one EXU access, issues a single read/write
// pulse to data memory, waits, and returns extended data or error to WBU.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/req_ready        EXU request handshake (ready only in IDLE)
//   req_we/size/unsigned       store flag, access size, load zero-extend
//   req_addr/req_wdata         byte address, LSB-aligned store data
//   resp_valid/resp_ready      WBU response handshake
//   resp_rdata/resp_err        extended load data, error flag
//   mem_ren/mem_wen            one-cycle read/write pulses
//   mem_raddr/mem_waddr        word-aligned addresses
//   mem_wdata/mem_wmask        lane-shifted data and byte mask
//   mem_rdata/mem_ready        read word and completion pulse
module ysyx_24080014_lsu #(
  parameter int unsigned WR_LAT  = 1,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RD,
    S_WAIT_WR,
    S_RESP
  } state_e;

  // Last count value before leaving a wait state; WR_LAT=0 acts as 1.
  localparam logic [7:0] WR_LAST =
    (WR_LAT == 0) ? 8'd0 : 8'(WR_LAT - 1);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        bad;
  logic [3:0]  base_mask;
  logic [31:0] rd_sh;
  logic [31:0] rd_ext;

  always_comb begin
    bad = 1'b0;
    unique case (1'b1)
      req_size == 2'd3: bad = 1'b1;
      req_size == 2'd2: bad = |req_addr[1:0];
      req_size == 2'd1: bad = req_addr[0];
      default:          bad = 1'b0;
    endcase
  end

  always_comb begin
    base_mask = 4'b1111;
    unique case (req_size)
      2'd0:    base_mask = 4'b0001;
      2'd1:    base_mask = 4'b0011;
      default: base_mask = 4'b1111;
    endcase
  end

  assign rd_sh = mem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    rd_ext = rd_sh;
    unique case (size_q)
      2'd0: rd_ext = uns_q ? {24'd0, rd_sh[7:0]}
                           : {{24{rd_sh[7]}}, rd_sh[7:0]};
      2'd1: rd_ext = uns_q ? {16'd0, rd_sh[15:0]}
                           : {{16{rd_sh[15]}}, rd_sh[15:0]};
      default: rd_ext = rd_sh;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata << {req_addr[1:0], 3'b000};
          wmask_d = base_mask << req_addr[1:0];
          cnt_d   = 8'd0;
          rdata_d = 32'd0;
          err_d   = bad;
          state_d = bad ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = 8'd0;
        state_d = we_q ? S_WAIT_WR : S_WAIT_RD;
      end
      S_WAIT_RD: begin
        cnt_d = cnt_q + 8'd1;
        // A completion in the timeout cycle still delivers data.
        if (mem_ready) begin
          rdata_d = rd_ext;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == TO_LAST) begin
          rdata_d = 32'd0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_WAIT_WR: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q >= WR_LAST) begin
          rdata_d = 32'd0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wmask_q <= 4'd0;
      cnt_q   <= 8'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_ren    = (state_q == S_ISSUE) && !we_q;
  assign mem_wen    = (state_q == S_ISSUE) && we_q;
  assign mem_raddr  = {addr_q[31:2], 2'b00};
  assign mem_waddr  = {addr_q[31:2], 2'b00};
  assign mem_wdata  = wdata_q;
  assign mem_wmask  = {4'b0000, wmask_q};

endmodule
